// File: rtl/hamming_pkg.sv
// Shared constants and FSM state type for the (15,11) Hamming decoder sequencer.
`timescale 1ns/1ps
package hamming_pkg;

  localparam int unsigned CW_BITS   = 15;
  localparam int unsigned DATA_BITS = 11;
  localparam int unsigned SYN_W     = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CORRECT,
    S_LOAD,
    S_SEND
  } state_t;

endpackage

// File: rtl/hamming_bit_counter.sv
// Modulo-N bit counter with enable, synchronous clear and a combinational wrap pulse.
`timescale 1ns/1ps
module hamming_bit_counter #(
  parameter int unsigned N = 15,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_decoder_ctrl.sv
// Sequencer for the (15,11) Hamming decoder datapath; all strobes are registered.
// Optional ERR_CNT output is enabled by defining HAMMING_ERR_CNT_EN.
`timescale 1ns/1ps
module hamming_decoder_ctrl
  import hamming_pkg::*;
(
  input  logic             CLK,
  input  logic             REST,
  input  logic             DEVICE_EN,
  input  logic             RX_TICK,
  input  logic             TX_TICK,
  input  logic [SYN_W-1:0] SYNDROME,
  output logic             RX_SHIFT,
  output logic             CW_LOAD,
  output logic             CORR_EN,
  output logic             OUT_LOAD,
  output logic             TX_SHIFT,
  output logic [IDX_W-1:0] BIT_IDX,
  output logic             FRAME_DONE,
  output logic             ERR_FLAG,
  output logic             OVERRUN
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  state_t             state, state_nx;
  logic               hold_full;
  logic               cw_due;
  logic               rx_en, rx_wrap;
  logic               tx_en, tx_wrap, tx_last;
  logic [IDX_W-1:0]   tx_cnt;
  logic               cw_load_nx, corr_en_nx, out_load_nx, tx_shift_nx, frame_done_nx;
  logic               err_flag_nx, overrun_set;

  assign rx_en   = DEVICE_EN && RX_TICK;
  assign tx_en   = DEVICE_EN && TX_TICK && (state == S_SEND);
  assign tx_last = (tx_cnt == IDX_W'(DATA_BITS - 1));

  hamming_bit_counter #(.N(CW_BITS), .W(IDX_W)) u_rx_cnt (
    .clk  (CLK),
    .rst  (REST),
    .en   (rx_en),
    .clr  (1'b0),
    .cnt  (BIT_IDX),
    .wrap (rx_wrap)
  );

  hamming_bit_counter #(.N(DATA_BITS), .W(IDX_W)) u_tx_cnt (
    .clk  (CLK),
    .rst  (REST),
    .en   (tx_en),
    .clr  (out_load_nx),
    .cnt  (tx_cnt),
    .wrap (tx_wrap)
  );

  always_comb begin
    state_nx      = state;
    corr_en_nx    = 1'b0;
    out_load_nx   = 1'b0;
    tx_shift_nx   = 1'b0;
    frame_done_nx = 1'b0;
    err_flag_nx   = ERR_FLAG;
    if (DEVICE_EN) begin
      unique case (state)
        S_IDLE: begin
          if (hold_full) state_nx = S_CHECK;
        end
        S_CHECK: begin
          err_flag_nx = (SYNDROME != '0);
          state_nx    = (SYNDROME != '0) ? S_CORRECT : S_LOAD;
        end
        S_CORRECT: begin
          corr_en_nx = 1'b1;
          state_nx   = S_LOAD;
        end
        S_LOAD: begin
          out_load_nx = 1'b1;
          state_nx    = S_SEND;
        end
        S_SEND: begin
          if (tx_en) begin
            tx_shift_nx   = 1'b1;
            frame_done_nx = tx_wrap;
            if (tx_last) state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // A full holding register is only safe to overwrite when it is emptied on the same edge.
  assign cw_load_nx  = DEVICE_EN && cw_due && (!hold_full || out_load_nx);
  assign overrun_set = DEVICE_EN && cw_due && hold_full && !out_load_nx;

  always_ff @(posedge CLK or posedge REST) begin
    if (REST) begin
      state      <= S_IDLE;
      hold_full  <= 1'b0;
      cw_due     <= 1'b0;
      RX_SHIFT   <= 1'b0;
      CW_LOAD    <= 1'b0;
      CORR_EN    <= 1'b0;
      OUT_LOAD   <= 1'b0;
      TX_SHIFT   <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR_FLAG   <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      state      <= state_nx;
      RX_SHIFT   <= rx_en;
      CW_LOAD    <= cw_load_nx;
      CORR_EN    <= corr_en_nx;
      OUT_LOAD   <= out_load_nx;
      TX_SHIFT   <= tx_shift_nx;
      FRAME_DONE <= frame_done_nx;
      ERR_FLAG   <= err_flag_nx;
      if (cw_load_nx)       hold_full <= 1'b1;
      else if (out_load_nx) hold_full <= 1'b0;
      // The load request survives a freeze and is resolved on the next enabled edge.
      if (rx_wrap)        cw_due <= 1'b1;
      else if (DEVICE_EN) cw_due <= 1'b0;
      if (overrun_set) OVERRUN <= 1'b1;
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic enter_correct;
  assign enter_correct = (state == S_CHECK) && (state_nx == S_CORRECT);

  always_ff @(posedge CLK or posedge REST) begin
    if (REST) begin
      ERR_CNT <= '0;
    end else if (enter_correct && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_decoder_ctrl.sv
// Self-checking bench for hamming_decoder_ctrl against an event-schedule reference model.
`timescale 1ns/1ps
module tb_hamming_decoder_ctrl;

  logic       CLK = 1'b0, REST = 1'b1, DEVICE_EN = 1'b0, RX_TICK = 1'b0, TX_TICK = 1'b0;
  logic [3:0] SYNDROME = 4'd0;
  logic       RX_SHIFT, CW_LOAD, CORR_EN, OUT_LOAD, TX_SHIFT, FRAME_DONE, ERR_FLAG, OVERRUN;
  logic [3:0] BIT_IDX;
`ifdef HAMMING_ERR_CNT_EN
  logic [7:0] ERR_CNT;
`endif

  int checks = 0, errors = 0;

  hamming_decoder_ctrl dut (
    .CLK(CLK), .REST(REST), .DEVICE_EN(DEVICE_EN), .RX_TICK(RX_TICK), .TX_TICK(TX_TICK),
    .SYNDROME(SYNDROME), .RX_SHIFT(RX_SHIFT), .CW_LOAD(CW_LOAD), .CORR_EN(CORR_EN),
    .OUT_LOAD(OUT_LOAD), .TX_SHIFT(TX_SHIFT), .BIT_IDX(BIT_IDX), .FRAME_DONE(FRAME_DONE),
    .ERR_FLAG(ERR_FLAG), .OVERRUN(OVERRUN)
`ifdef HAMMING_ERR_CNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: time counts enabled edges only; decoder work is a schedule of events.
  int   et, rx_n, tx_n, err_at, corr_at, load_at, err_cnt_m, m_fd;
  bit   cw_due_m, holding, job, sending, err_flag_m, ovr_m, err_val;
  bit   e_rx, e_cw, e_corr, e_ol, e_tx, e_fd;
  logic [3:0] hold_syn, next_syn;

  // Observation tallies
  int cyc = 0, mism, mm_cyc;
  logic [11:0] mm_got, mm_exp;
  int o_rx, o_cw, o_corr, o_ol, o_tx, o_fd, t_rx, t_cw, t_corr, t_ol;

  task automatic model_reset();
    et = 0; rx_n = 0; tx_n = 0; err_at = 0; corr_at = 0; load_at = 0; err_cnt_m = 0; m_fd = 0;
    cw_due_m = 0; holding = 0; job = 0; sending = 0; err_flag_m = 0; ovr_m = 0; err_val = 0;
    e_rx = 0; e_cw = 0; e_corr = 0; e_ol = 0; e_tx = 0; e_fd = 0; hold_syn = 4'd0;
  endtask

  task automatic model_step(input logic rx, input logic tx, input logic en);
    e_rx = 0; e_cw = 0; e_corr = 0; e_ol = 0; e_tx = 0; e_fd = 0;
    if (!en) return;
    et++;
    if (sending && tx) begin
      e_tx = 1; tx_n++;
      if (tx_n == 11) begin e_fd = 1; sending = 0; m_fd++; end
    end
    if (job && et == err_at) begin
      err_flag_m = err_val;
      if (err_val && err_cnt_m < 255) err_cnt_m++;
    end
    if (job && et == corr_at) e_corr = 1;
    if (job && et == load_at) begin
      e_ol = 1; holding = 0; job = 0; sending = 1; tx_n = 0;
    end
    if (cw_due_m) begin
      cw_due_m = 0;
      if (holding) ovr_m = 1;
      else begin e_cw = 1; holding = 1; hold_syn = next_syn; end
    end
    if (rx) begin
      e_rx = 1; rx_n++;
      if (rx_n == 15) begin rx_n = 0; cw_due_m = 1; end
    end
    if (holding && !job && !sending) begin
      job = 1; err_val = (hold_syn != 0);
      err_at = et + 2; corr_at = err_val ? et + 3 : 0; load_at = err_val ? et + 4 : et + 3;
    end
  endtask

  task automatic clear_obs();
    mism = 0; o_rx = 0; o_cw = 0; o_corr = 0; o_ol = 0; o_tx = 0; o_fd = 0;
    t_rx = 0; t_cw = 0; t_corr = 0; t_ol = 0;
  endtask

  task automatic tick(input logic rx, input logic tx, input logic en);
    logic [11:0] got, ex;
    @(negedge CLK);
    RX_TICK = rx; TX_TICK = tx; DEVICE_EN = en;
    @(posedge CLK);
    cyc++;
    model_step(rx, tx, en);
    #1;
    got = {RX_SHIFT, CW_LOAD, CORR_EN, OUT_LOAD, TX_SHIFT, FRAME_DONE, ERR_FLAG, OVERRUN, BIT_IDX};
    ex  = {e_rx, e_cw, e_corr, e_ol, e_tx, e_fd, err_flag_m, ovr_m, 4'(rx_n)};
    if (got !== ex) begin
      if (mism == 0) begin mm_cyc = cyc; mm_got = got; mm_exp = ex; end
      mism++;
    end
`ifdef HAMMING_ERR_CNT_EN
    if (ERR_CNT !== 8'(err_cnt_m)) begin
      if (mism == 0) begin mm_cyc = cyc; mm_got = {4'd0, ERR_CNT}; mm_exp = 12'(err_cnt_m); end
      mism++;
    end
`endif
    if (RX_SHIFT === 1'b1) begin o_rx++; t_rx = cyc; end
    if (CW_LOAD === 1'b1)  begin o_cw++; t_cw = cyc; end
    if (CORR_EN === 1'b1)  begin o_corr++; t_corr = cyc; end
    if (OUT_LOAD === 1'b1) begin o_ol++; t_ol = cyc; end
    if (TX_SHIFT === 1'b1) o_tx++;
    if (FRAME_DONE === 1'b1) o_fd++;
    SYNDROME = hold_syn;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    REST = 1'b1; RX_TICK = 1'b0; TX_TICK = 1'b0;
    repeat (2) @(negedge CLK);
    REST = 1'b0;
    model_reset();
    SYNDROME = 4'd0;
  endtask

  task automatic rx_bits(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic wait_out_load(input int target);
    for (int i = 0; i < 20 && o_ol < target; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain_tx(input int target, input int budget);
    for (int i = 0; i < budget && o_fd < target; i++) tick(1'b0, 1'(i % 2), 1'b1);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    REST = 1'b1;
    repeat (3) @(negedge CLK);
    got = {RX_SHIFT, CW_LOAD, CORR_EN, OUT_LOAD, TX_SHIFT, FRAME_DONE, ERR_FLAG, OVERRUN, BIT_IDX};
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL reset_outputs got %h want 000", got); end
    REST = 1'b0;
    model_reset();
    clear_obs();
    tick(1'b0, 1'b0, 1'b1);
    got = {RX_SHIFT, CW_LOAD, CORR_EN, OUT_LOAD, TX_SHIFT, FRAME_DONE, ERR_FLAG, OVERRUN, BIT_IDX};
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL reset_release got %h want 000", got); end
`ifdef HAMMING_ERR_CNT_EN
    checks++;
    if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", ERR_CNT); end
`endif
  endtask

  task automatic test_clean_frame();
    clear_obs();
    next_syn = 4'd0;
    rx_bits(15, 3);
    wait_out_load(1);
    drain_tx(1, 200);
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL clean_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
    checks++;
    if (t_cw - t_rx !== 1) begin errors++; $display("FAIL clean_cw_after_rx got %0d want 1", t_cw - t_rx); end
    checks++;
    if (t_ol - t_cw !== 3) begin errors++; $display("FAIL clean_latency got %0d want 3", t_ol - t_cw); end
    checks++;
    if (o_corr !== 0) begin errors++; $display("FAIL clean_corr_count got %0d want 0", o_corr); end
    checks++;
    if (o_tx !== 11 || o_fd !== 1) begin errors++; $display("FAIL clean_tx got %0d/%0d want 11/1", o_tx, o_fd); end
    checks++;
    if (ERR_FLAG !== 1'b0) begin errors++; $display("FAIL clean_err_flag got %b want 0", ERR_FLAG); end
  endtask

  task automatic test_error_frame();
    clear_obs();
    next_syn = 4'd5;
    rx_bits(15, 2);
    wait_out_load(1);
    drain_tx(1, 200);
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL error_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
    checks++;
    if (o_corr !== 1 || t_corr <= t_cw || t_corr >= t_ol) begin
      errors++; $display("FAIL error_corr count %0d at %0d want 1 between %0d and %0d", o_corr, t_corr, t_cw, t_ol);
    end
    checks++;
    if (t_ol - t_cw !== 4) begin errors++; $display("FAIL error_latency got %0d want 4", t_ol - t_cw); end
    checks++;
    if (ERR_FLAG !== 1'b1) begin errors++; $display("FAIL error_err_flag got %b want 1", ERR_FLAG); end
`ifdef HAMMING_ERR_CNT_EN
    checks++;
    if (ERR_CNT !== 8'd1) begin errors++; $display("FAIL error_err_cnt got %0d want 1", ERR_CNT); end
`endif
  endtask

  task automatic test_overrun();
    do_reset();
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      next_syn = 4'($urandom_range(0, 15));
      rx_bits(15, 1);
    end
    repeat (10) tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (o_cw !== 2 || OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_drop cw %0d ovr %b want 2 1", o_cw, OVERRUN); end
    drain_tx(2, 400);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1);
    checks++;
    if (o_tx !== 22 || o_fd !== 2) begin errors++; $display("FAIL overrun_sent tx %0d fd %0d want 22 2", o_tx, o_fd); end
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", OVERRUN); end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL overrun_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
  endtask

  task automatic test_freeze();
    int strobes_before;
    do_reset();
    clear_obs();
    next_syn = 4'd0;
    rx_bits(7, 2);
    checks++;
    if (BIT_IDX !== 4'd7) begin errors++; $display("FAIL freeze_pre_idx got %0d want 7", BIT_IDX); end
    strobes_before = o_rx + o_cw + o_corr + o_ol + o_tx + o_fd;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    checks++;
    if (BIT_IDX !== 4'd7) begin errors++; $display("FAIL freeze_idx got %0d want 7", BIT_IDX); end
    checks++;
    if (o_rx + o_cw + o_corr + o_ol + o_tx + o_fd !== strobes_before) begin
      errors++; $display("FAIL freeze_strobes got %0d want %0d", o_rx + o_cw + o_corr + o_ol + o_tx + o_fd, strobes_before);
    end
    rx_bits(8, 2);
    wait_out_load(1);
    drain_tx(1, 200);
    checks++;
    if (o_rx !== 15 || o_cw !== 1 || o_fd !== 1) begin errors++; $display("FAIL freeze_resume rx %0d cw %0d fd %0d want 15 1 1", o_rx, o_cw, o_fd); end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL freeze_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
  endtask

  task automatic test_streaming();
    int sent = 0;
    do_reset();
    clear_obs();
    for (int c = 0; c < 3000 && o_fd < 3; c++) begin
      logic rx;
      rx = (c % 11 == 0) && (sent < 45);
      if (rx) begin sent++; next_syn = 4'($urandom_range(0, 15)); end
      tick(rx, 1'(c % 15 == 0), 1'b1);
    end
    checks++;
    if (o_fd !== 3 || o_tx !== 33) begin errors++; $display("FAIL stream_frames fd %0d tx %0d want 3 33", o_fd, o_tx); end
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL stream_overrun got %b want 0", OVERRUN); end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL stream_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
  endtask

  task automatic test_reset_mid_send();
    logic [11:0] got;
    logic [3:0]  syn2;
    do_reset();
    clear_obs();
    next_syn = 4'd9;
    rx_bits(15, 1);
    wait_out_load(1);
    for (int i = 0; i < 100 && o_tx < 6; i++) tick(1'b0, 1'(i % 2), 1'b1);
    #2;
    REST = 1'b1;
    #1;
    got = {RX_SHIFT, CW_LOAD, CORR_EN, OUT_LOAD, TX_SHIFT, FRAME_DONE, ERR_FLAG, OVERRUN, BIT_IDX};
    checks++;
    if (o_tx !== 6 || got !== 12'h000) begin errors++; $display("FAIL midsend_reset tx %0d outputs %h want 6 000", o_tx, got); end
    do_reset();
    clear_obs();
    syn2 = 4'($urandom_range(0, 15));
    next_syn = syn2;
    rx_bits(15, 2);
    wait_out_load(1);
    drain_tx(1, 200);
    checks++;
    if (o_fd !== 1 || o_tx !== 11 || ERR_FLAG !== (syn2 != 4'd0)) begin
      errors++; $display("FAIL midsend_next fd %0d tx %0d err %b want 1 11 %b", o_fd, o_tx, ERR_FLAG, syn2 != 4'd0);
    end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL midsend_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
  endtask

  task automatic test_random();
    do_reset();
    clear_obs();
    for (int i = 0; i < 1500; i++) begin
      logic rx;
      rx = ($urandom_range(0, 3) == 0);
      if (rx) next_syn = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tick(rx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0));
    end
    checks++;
    if (o_fd !== m_fd) begin errors++; $display("FAIL random_frames got %0d want %0d", o_fd, m_fd); end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL random_model mismatches %0d want 0 (cyc %0d got %h exp %h)", mism, mm_cyc, mm_got, mm_exp); end
  endtask

  initial begin
    next_syn = 4'd0;
    model_reset();
    clear_obs();
    test_reset();
    test_clean_frame();
    test_error_frame();
    test_overrun();
    test_freeze();
    test_streaming();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
